// File: rtl/adder_checker.sv
`default_nettype none
// ============================================================================
//  Module      : adder_checker
//  Description : Exhaustive self-test sweep for a WIDTH-bit adder. Drives every
//                operand pair, compares {carry,sum} against A+B and counts
//                mismatches. Optional first-failure capture is enabled by
//                defining ADDER_CHECKER_FIRST_FAIL_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_checker #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [WIDTH-1:0]   dataA,
  output logic [WIDTH-1:0]   dataB,
  input  logic [WIDTH-1:0]   sum,
  input  logic               carry,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);

  localparam int CW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW:0]     err_q;
  logic [CW:0]     err_d;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;

  logic [WIDTH:0]  w_expect;
  logic            w_mismatch;
  logic            w_last;
  logic            w_start_acc;

  // Operand counter: upper half is A, lower half is B.
  assign w_expect    = {1'b0, cnt_q[CW-1:WIDTH]} + {1'b0, cnt_q[WIDTH-1:0]};
  assign w_mismatch  = (state_q == S_RUN) && ({carry, sum} != w_expect);
  assign err_d       = err_q + {{CW{1'b0}}, w_mismatch};
  assign w_last      = &cnt_q;
  assign w_start_acc = start && (state_q != S_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        S_RUN: begin
          err_q <= err_d;
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else if (w_last) begin
            // All-ones pair was just compared; operands stay at all-ones.
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADDER_CHECKER_FIRST_FAIL_EN
  logic [WIDTH-1:0] fail_a_q;
  logic [WIDTH-1:0] fail_b_q;
  logic             seen_q;

  // seen_q distinguishes a real capture of (0,0) from the cleared state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_a_q <= '0;
      fail_b_q <= '0;
      seen_q   <= 1'b0;
    end else if (w_start_acc) begin
      fail_a_q <= '0;
      fail_b_q <= '0;
      seen_q   <= 1'b0;
    end else if (w_mismatch && !seen_q) begin
      fail_a_q <= cnt_q[CW-1:WIDTH];
      fail_b_q <= cnt_q[WIDTH-1:0];
      seen_q   <= 1'b1;
    end
  end

  assign fail_a = fail_a_q;
  assign fail_b = fail_b_q;
`else
  logic w_unused;
  assign w_unused = w_start_acc;
  assign fail_a   = '0;
  assign fail_b   = '0;
`endif

  assign dataA     = cnt_q[CW-1:WIDTH];
  assign dataB     = cnt_q[WIDTH-1:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule
`default_nettype wire

// File: doc/adder_checker.md
ADDER_CHECKER -- requirements
Module: adder_checker

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits of the adder under test.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse; begins an exhaustive sweep.
REQ-005 abort  input  1  one-cycle pulse; stops a sweep in progress.
REQ-006 dataA  output  WIDTH  operand A driven to the adder under test; registered.
REQ-007 dataB  output  WIDTH  operand B driven to the adder under test; registered.
REQ-008 sum  input  WIDTH  sum returned by the adder (combinational path from dataA/dataB).
REQ-009 carry  input  1  carry-out returned by the adder.
REQ-010 busy  output  1  high while a sweep is running.
REQ-011 done  output  1  high after a completed sweep, until the next start or reset.
REQ-012 pass  output  1  valid while done is high; 1 means zero mismatches.
REQ-013 err_count  output  2*WIDTH+1  number of mismatching operand pairs in the current or last sweep.
REQ-014 fail_a, fail_b  output  WIDTH each  operands of the first mismatch (see Configuration).

Function
REQ-015 The block SHALL implement the FSM states IDLE, RUN and DONE, with IDLE entered from reset.
REQ-016 In IDLE or DONE, start=1 SHALL enter RUN on the next edge, load {dataA,dataB}=0, clear err_count, and clear the first-fail capture.
REQ-017 In RUN, each cycle SHALL compare {carry,sum} against the (WIDTH+1)-bit value dataA+dataB and increment err_count by 1 on mismatch.
REQ-018 In RUN, {dataA,dataB} SHALL act as a 2*WIDTH-bit counter (dataA = MS half) that increments by 1 per cycle, producing the order (0,0),(0,1)..(0,15),(1,0)..(15,15) for WIDTH=4.
REQ-019 The cycle comparing the all-ones pair SHALL be the last RUN cycle, and the next state SHALL be DONE, so a sweep takes exactly 2^(2*WIDTH) RUN cycles (256 for WIDTH=4).
REQ-020 On entering DONE, dataA and dataB SHALL hold all-ones, done=1, busy=0, and pass=(err_count==0).
REQ-021 busy SHALL equal (state==RUN), and done SHALL equal (state==DONE).
REQ-022 abort=1 in RUN SHALL return to IDLE on the next edge: the compare of that cycle is still counted, err_count is held, and done stays 0.
REQ-023 When start and abort are both high, abort SHALL win in RUN, start SHALL win in IDLE/DONE, and abort SHALL be ignored outside RUN.
REQ-024 start in RUN SHALL be ignored, and the sweep SHALL continue unaffected.
REQ-025 err_count SHALL be wide enough that it cannot overflow (maximum 2^(2*WIDTH)), so no saturation logic is required.
REQ-026 pass SHALL be 0 in IDLE and RUN.

Reset
REQ-027 With rst_n=0 at a rising edge, the block SHALL set state=IDLE, dataA=0, dataB=0, err_count=0, fail_a=0, fail_b=0, busy=0, done=0 and pass=0.
REQ-028 Reset asserted mid-RUN SHALL discard the sweep with no partial result retained, and start SHALL be honoured on the first edge after rst_n returns high.

Configuration
REQ-029 Macro ADDER_CHECKER_FIRST_FAIL_EN, when defined, SHALL make fail_a/fail_b capture dataA/dataB on the first mismatch of a sweep and hold them until the next start or reset.
REQ-030 Without ADDER_CHECKER_FIRST_FAIL_EN, fail_a and fail_b SHALL be constant 0, the ports SHALL remain present, and all other behaviour SHALL be identical.

Verification
REQ-031 Correct 4-bit adder, start pulse -> busy=1 for 256 cycles, then done=1, pass=1, err_count=0, dataA=dataB=4'hF.
REQ-032 Adder with carry stuck at 0 -> done=1, pass=0, err_count=120; with macro, fail_a=1, fail_b=15.
REQ-033 Adder with sum[0] stuck at 0 -> err_count=128; with macro, fail_a=0, fail_b=1.
REQ-034 Correct adder, abort on the 10th RUN cycle -> IDLE next cycle, busy=0, done=0, err_count=0; a later start gives a full 256-cycle sweep with pass=1.
REQ-035 rst_n=0 for one cycle mid-sweep with a faulty adder -> all outputs at reset values, err_count=0; a following start sweeps from (0,0).
REQ-036 Second start while in DONE after a failing sweep with the adder now correct -> err_count cleared on entering RUN; final pass=1.
